// File: rtl/obj_pkg.sv
// Shared definitions for the display object table: slot word layout,
// object type encodings and the update FSM states.
package obj_pkg;

  localparam int OBJ_W = 26;

  localparam int FRAME_W   = 3;
  localparam int FRAME_LSB = 23;
  localparam int TYPE_W    = 2;
  localparam int TYPE_LSB  = 21;
  localparam int X_W       = 11;
  localparam int X_LSB     = 10;
  localparam int Y_W       = 10;
  localparam int Y_LSB     = 0;

  typedef enum logic [TYPE_W-1:0] {
    OBJ_TYPE_0 = 2'd0,
    OBJ_TYPE_1 = 2'd1,
    OBJ_TYPE_2 = 2'd2,
    OBJ_TYPE_3 = 2'd3
  } obj_type_e;

  typedef struct packed {
    logic [FRAME_W-1:0] frame;
    obj_type_e          otype;
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
  } obj_t;

  typedef enum logic {
    ST_IDLE,
    ST_UPDATE
  } state_e;

endpackage

// File: rtl/obj_prio_enc.sv
// Lowest-index free slot encoder: returns the index of the lowest set bit
// of free and whether any bit is set.
module obj_prio_enc #(
  parameter int N     = 5,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     free,
  output logic [IDX_W-1:0] index,
  output logic             any_free
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    index    = '0;
    any_free = 1'b0;
    // Scan downwards so the lowest free slot is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (free[i]) begin
        index    = IDX_W'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/obj_table.sv
// Object table for the display: spawns objects into free slots and, once per
// vsync falling edge, scrolls them left, animates them and despawns off-screen ones.
module obj_table
  import obj_pkg::*;
#(
  parameter int N_OBJ     = 5,
  parameter int FRAME_DIV = 8,
  parameter int N_FRAMES  = 8,
  parameter int SCROLL    = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   vsync,
  input  logic                   spawn_valid,
  output logic                   spawn_ready,
  input  logic [1:0]             spawn_type,
  input  logic [10:0]            spawn_x,
  input  logic [9:0]             spawn_y,
  input  logic                   clear,
  output logic [OBJ_W*N_OBJ-1:0] objs,
  output logic [N_OBJ-1:0]       active,
  output logic                   busy,
  output logic                   tick_missed
);

  localparam int IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(N_OBJ - 1);
  localparam logic [7:0]         DIV_LAST   = 8'(FRAME_DIV - 1);
  localparam logic [X_W-1:0]     SCROLL_X   = X_W'(SCROLL);
  localparam logic [FRAME_W-1:0] FRAME_MASK = FRAME_W'(N_FRAMES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         div_q, div_d;
  logic               advance_q, advance_d;
  logic               missed_q, missed_d;
  logic               vsync_q;
  logic [N_OBJ-1:0]   active_q, active_d;
  obj_t               slot_q [N_OBJ];
  obj_t               slot_d [N_OBJ];

  logic               tick;
  logic [IDX_W-1:0]   free_idx;
  logic               any_free;
  logic               spawn_fire;
  obj_t               cur;

  obj_prio_enc #(
    .N     (N_OBJ),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .free     (~active_q),
    .index    (free_idx),
    .any_free (any_free)
  );

  assign tick        = vsync_q & ~vsync;
  assign spawn_ready = (state_q == ST_IDLE) & ~clear & any_free;
  assign spawn_fire  = spawn_valid & spawn_ready;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    div_d     = div_q;
    advance_d = advance_q;
    missed_d  = missed_q;
    active_d  = active_q;
    slot_d    = slot_q;
    cur       = slot_q[idx_q];

    if (clear) begin
      // Slot words stay put; clearing the active bits is enough to hide them.
      active_d = '0;
      div_d    = '0;
      state_d  = ST_IDLE;
      idx_d    = '0;
      missed_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (spawn_fire) begin
            slot_d[free_idx]   = '{frame: '0, otype: obj_type_e'(spawn_type),
                                   x: spawn_x, y: spawn_y};
            active_d[free_idx] = 1'b1;
          end
          if (tick) begin
            state_d   = ST_UPDATE;
            idx_d     = '0;
            advance_d = (div_q == DIV_LAST);
            div_d     = (div_q == DIV_LAST) ? 8'd0 : div_q + 8'd1;
          end
        end
        ST_UPDATE: begin
          if (tick) missed_d = 1'b1;
          if (active_q[idx_q]) begin
            if (cur.x < SCROLL_X) begin
              active_d[idx_q] = 1'b0;
            end else begin
              slot_d[idx_q].x = cur.x - SCROLL_X;
              if (advance_q) slot_d[idx_q].frame = (cur.frame + 3'd1) & FRAME_MASK;
            end
          end
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      div_q     <= '0;
      advance_q <= 1'b0;
      missed_q  <= 1'b0;
      vsync_q   <= 1'b0;
      active_q  <= '0;
      // NOTE: slots are plain flops, not a RAM, so they take the reset too and
      // objs reads zero the moment reset asserts.
      for (int i = 0; i < N_OBJ; i++) slot_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      div_q     <= div_d;
      advance_q <= advance_d;
      missed_q  <= missed_d;
      vsync_q   <= vsync;
      active_q  <= active_d;
      slot_q    <= slot_d;
    end
  end

  always_comb begin
    objs = '0;
    for (int i = 0; i < N_OBJ; i++) begin
      objs[i*OBJ_W + FRAME_LSB +: FRAME_W] = slot_q[i].frame;
      objs[i*OBJ_W + TYPE_LSB  +: TYPE_W]  = slot_q[i].otype;
      objs[i*OBJ_W + X_LSB     +: X_W]     = slot_q[i].x;
      objs[i*OBJ_W + Y_LSB     +: Y_W]     = slot_q[i].y;
    end
  end

  assign active      = active_q;
  assign busy        = (state_q == ST_UPDATE);
  assign tick_missed = missed_q;

endmodule

// File: tb/tb_obj_table.sv
// Directed bench for obj_table with default parameters (5 slots, FRAME_DIV 8,
// 8 frames, SCROLL 1); expected slot words are hand-computed.
module tb_obj_table;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         vsync = 1'b0;
  logic         spawn_valid = 1'b0;
  logic         spawn_ready;
  logic [1:0]   spawn_type = '0;
  logic [10:0]  spawn_x = '0;
  logic [9:0]   spawn_y = '0;
  logic         clear = 1'b0;
  logic [129:0] objs;
  logic [4:0]   active;
  logic         busy;
  logic         tick_missed;

  int checks = 0;
  int errors = 0;

  obj_table dut (
    .clock       (clock),
    .reset       (reset),
    .vsync       (vsync),
    .spawn_valid (spawn_valid),
    .spawn_ready (spawn_ready),
    .spawn_type  (spawn_type),
    .spawn_x     (spawn_x),
    .spawn_y     (spawn_y),
    .clear       (clear),
    .objs        (objs),
    .active      (active),
    .busy        (busy),
    .tick_missed (tick_missed)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [129:0] obs, input logic [129:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [25:0] mk(input int f, input int t, input int x, input int y);
    return {3'(f), 2'(t), 11'(x), 10'(y)};
  endfunction

  function automatic logic [25:0] slot(input int i);
    return objs[i*26 +: 26];
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $error("FAIL idle_timeout: busy still high after %0d cycles", n);
    end
  endtask

  task automatic do_tick();
    int n;
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    step();
    wait_idle(n);
  endtask

  task automatic spawn(input int t, input int x, input int y);
    spawn_valid = 1'b1;
    spawn_type  = 2'(t);
    spawn_x     = 11'(x);
    spawn_y     = 10'(y);
    step();
    spawn_valid = 1'b0;
  endtask

  initial begin
    int n;

    // Reset state
    #1;
    check("rst_objs", objs, '0);
    check("rst_active", active, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_missed", tick_missed, 1'b0);
    step();
    reset = 1'b1;
    step();
    check("rdy_after_rst", spawn_ready, 1'b1);

    // Spawn into slot 0
    spawn(2, 256, 256);
    check("spawn_slot0", slot(0), mk(0, 2, 256, 256));
    check("spawn_active", active, 5'b00001);

    // Scroll and despawn: object at x 2 lands in slot 1
    spawn(1, 2, 5);
    check("spawn_slot1", slot(1), mk(0, 1, 2, 5));
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    step();
    check("busy_in_pass", busy, 1'b1);
    wait_idle(n);
    check("pass_len", 130'(n), 130'(5));
    check("scroll_t1", slot(1), mk(0, 1, 1, 5));
    check("scroll_s0_t1", slot(0), mk(0, 2, 255, 256));
    do_tick();
    check("scroll_t2", slot(1), mk(0, 1, 0, 5));
    check("active_t2", active, 5'b00011);
    do_tick();
    check("despawn_t3", active, 5'b00001);
    check("despawn_word_kept", slot(1), mk(0, 1, 0, 5));

    // Animation: 16 ticks total -> frame 2
    for (int i = 0; i < 13; i++) do_tick();
    check("anim_16", slot(0), mk(2, 2, 240, 256));
    for (int i = 0; i < 40; i++) do_tick();
    check("anim_56_f7", slot(0), mk(7, 2, 200, 256));
    for (int i = 0; i < 8; i++) do_tick();
    check("anim_64_wrap", slot(0), mk(0, 2, 192, 256));

    // Full table and lowest-free ordering
    spawn(0, 100, 1);
    spawn(1, 1, 2);
    spawn(2, 300, 3);
    spawn(3, 400, 4);
    check("full_active", active, 5'b11111);
    check("full_ready", spawn_ready, 1'b0);
    check("full_slot2", slot(2), mk(0, 1, 1, 2));
    do_tick();
    do_tick();
    check("slot2_freed", active, 5'b11011);
    check("ready_again", spawn_ready, 1'b1);
    spawn(3, 50, 60);
    check("refill_slot2", slot(2), mk(0, 3, 50, 60));
    check("refill_active", active, 5'b11111);

    // clear with spawn_valid: nothing written, everything flushed
    clear       = 1'b1;
    spawn_valid = 1'b1;
    spawn_type  = 2'd1;
    spawn_x     = 11'd10;
    spawn_y     = 10'd10;
    #1;
    check("clear_blocks_ready", spawn_ready, 1'b0);
    step();
    clear       = 1'b0;
    spawn_valid = 1'b0;
    check("clear_active", active, '0);
    check("clear_word_kept", slot(0), mk(0, 2, 190, 256));

    // Spawn in the tick cycle: new object is scrolled by that pass
    vsync = 1'b1;
    step();
    vsync       = 1'b0;
    spawn_valid = 1'b1;
    spawn_type  = 2'd0;
    spawn_x     = 11'd20;
    spawn_y     = 10'd30;
    step();
    spawn_valid = 1'b0;
    check("tick_spawn_busy", busy, 1'b1);
    wait_idle(n);
    check("tick_spawn_word", slot(0), mk(0, 0, 19, 30));
    check("tick_spawn_active", active, 5'b00001);

    // Tick while busy is dropped and flagged
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    step();
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    step();
    check("missed_set", tick_missed, 1'b1);
    wait_idle(n);
    check("missed_pass_once", slot(0), mk(0, 0, 18, 30));
    do_tick();
    check("missed_sticky", tick_missed, 1'b1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("missed_cleared", tick_missed, 1'b0);

    // Reset in the middle of a pass
    spawn(2, 500, 7);
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    step();
    step();
    check("pre_rst_busy", busy, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_objs", objs, '0);
    check("mid_rst_active", active, '0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_missed", tick_missed, 1'b0);
    reset = 1'b1;
    step();
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_active", active, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/obj_table.md
OBJ_TABLE -- requirements
Module: obj_table

Interface
REQ-001 Parameter N_OBJ, default 5: number of object slots; legal range 1-16.
REQ-002 Parameter FRAME_DIV, default 8: vsync ticks per animation step; legal range 1-255.
REQ-003 Parameter N_FRAMES, default 8: animation frames; power of two, at most 8.
REQ-004 Parameter SCROLL, default 1: pixels subtracted from x per tick; legal range 0-63.
REQ-005 Port clock, input, 1: 65 MHz pixel clock.
REQ-006 Port reset, input, 1: reset, asynchronous and active-low (0 = reset asserted).
REQ-007 Port vsync, input, 1: active-high vsync from xvga, synchronous to clock.
REQ-008 Port spawn_valid, input, 1: spawn request.
REQ-009 Port spawn_ready, output, 1: spawn can be accepted this cycle.
REQ-010 Port spawn_type, input, 2: object type.
REQ-011 Port spawn_x, input, 11: initial x position.
REQ-012 Port spawn_y, input, 10: initial y position.
REQ-013 Port clear, input, 1: synchronous flush of all slots.
REQ-014 Port objs, output, 26*N_OBJ: packed slot words; slot i occupies bits [26i+25:26i].
REQ-015 Port active, output, N_OBJ: per-slot occupied flag.
REQ-016 Port busy, output, 1: high while the update pass runs.
REQ-017 Port tick_missed, output, 1: sticky flag, set when a tick is lost.

Function
REQ-018 Slot word layout: [25:23] frame, [22:21] type, [20:10] x, [9:0] y; matches the existing display object format.
REQ-019 Tick = vsync falling edge; detected with one registered copy of vsync.
REQ-020 FSM has two states, IDLE and UPDATE.
- IDLE -> UPDATE on a tick.
- UPDATE visits slot index 0..N_OBJ-1, one slot per cycle.
- UPDATE -> IDLE after the last slot; pass length is exactly N_OBJ cycles.
- busy = (state == UPDATE).
REQ-021 Animation divider: 8-bit div_cnt counts ticks 0..FRAME_DIV-1 and wraps to 0.
- The pass advances frames when div_cnt == FRAME_DIV-1 at the tick.
REQ-022 In UPDATE, each active slot is processed as follows:
- If x < SCROLL: active clears; word unchanged.
- Otherwise: x <= x - SCROLL.
- On an advancing pass, frame <= (frame + 1) mod N_FRAMES.
- Inactive slots are untouched.
REQ-023 spawn_ready = IDLE & ~clear & (at least one slot inactive).
REQ-024 Spawn is accepted when spawn_valid & spawn_ready.
- Target is the lowest-index inactive slot.
- Slot is written {frame 0, type, x, y}; active set; visible on objs/active next cycle.
REQ-025 A spawn in the same cycle as a tick is accepted, and the FSM enters UPDATE next cycle; the new object is included in that pass.
REQ-026 A tick detected while in UPDATE is dropped and sets tick_missed; the flag clears only on reset or clear.
REQ-027 clear has priority over spawn and tick.
- All active bits clear, div_cnt <= 0, FSM <= IDLE, tick_missed <= 0.
- Slot words are retained but masked by active.
REQ-028 Table full: spawn_ready = 0; a held spawn_valid completes once a slot frees.
REQ-029 SCROLL = 0: x never changes and objects are never despawned by scrolling.
REQ-030 All outputs are registered or decoded directly from registers; no combinational path from spawn_valid to spawn_ready.

Reset
REQ-031 While reset = 0, the following hold immediately, independent of clock:
- objs = 0, active = 0, busy = 0, tick_missed = 0.
- div_cnt = 0, FSM = IDLE, vsync history = 0.
REQ-032 Reset during UPDATE aborts the pass; no partial state survives.
REQ-033 The first falling edge after reset release that follows a registered vsync = 1 is a valid tick.

Structure
REQ-034 Shared package obj_pkg holds:
- field offsets and widths for frame, type, x, y;
- OBJ_W = 26;
- the type encodings.
REQ-035 One sub-module, obj_prio_enc: N_OBJ-input lowest-free-slot encoder, outputs index and any_free.
REQ-036 No memories; slots are flip-flop arrays so that objs is fully parallel for display.

Verification
REQ-037 Directed scenario, spawn: after reset, spawn type 2 at x 256, y 256 -> slot 0 = {0, 2, 256, 256}, active = 00001.
REQ-038 Directed scenario, scroll and despawn: SCROLL = 1, object at x 2, ticks 1-3 -> x 1, then x 0, then active clears on tick 3.
REQ-039 Directed scenario, animation: FRAME_DIV = 8, 16 ticks -> frame 2; frame 7 advances to frame 0.
REQ-040 Directed scenario, full table and ordering:
- Fill 5 slots -> spawn_ready = 0.
- Despawn slot 2 -> next spawn lands in slot 2.
REQ-041 Directed scenario, simultaneous events:
- Spawn in the tick cycle -> new object x already decremented after the pass.
- Tick while busy -> tick_missed = 1.
REQ-042 Directed scenario, reset and clear:
- Reset asserted mid-UPDATE -> all outputs 0 immediately.
- clear together with spawn_valid -> no slot written.
